// File: rtl/systolic_deskew.sv
// Deskews per-lane systolic results into aligned rows and buffers them in a circular FIFO (option: DESKEW_ERR_CHECK_EN).
// Latency: lane-0 sample edge E0 -> row visible at out_data with out_valid=1 after edge E0+LANES.
// Backpressure: none toward the array; a row that finds the FIFO full is dropped and sets overflow.
module systolic_deskew #(
    parameter int LANES     = 16,
    parameter int DATA_W    = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic [LANES-1:0]            in_lane_valid,
    input  logic [LANES*DATA_W-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_W-1:0]     out_data,
    output logic [$clog2(OUT_DEPTH):0]  fifo_level,
    output logic                        overflow,
    output logic                        skew_err
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int PW = AW + 1;

    logic [LANES*DATA_W-1:0] aligned_dat;
    logic                    av;

    // Data lines shift unconditionally; clear leaves their contents alone.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int STAGES = LANES - j;
        logic [DATA_W-1:0] dly_dat [STAGES];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 0; s < STAGES; s++) dly_dat[s] <= '0;
            end else begin
                dly_dat[0] <= in_data[j*DATA_W +: DATA_W];
                for (int s = 1; s < STAGES; s++) dly_dat[s] <= dly_dat[s-1];
            end
        end

        assign aligned_dat[j*DATA_W +: DATA_W] = dly_dat[STAGES-1];
    end

`ifdef DESKEW_ERR_CHECK_EN
    logic [LANES-1:0] last_vld;
    logic             skew_hit;
    logic             skew_q;

    for (genvar j = 0; j < LANES; j++) begin : g_vld
        localparam int STAGES = LANES - j;
        logic [STAGES-1:0] dly_vld;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dly_vld <= '0;
            end else if (clear) begin
                dly_vld <= '0;
            end else begin
                dly_vld[0] <= in_lane_valid[j];
                for (int s = 1; s < STAGES; s++) dly_vld[s] <= dly_vld[s-1];
            end
        end

        assign last_vld[j] = dly_vld[STAGES-1];
    end

    assign av       = &last_vld;
    assign skew_hit = (|last_vld) && !av;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      skew_q <= 1'b0;
        else if (clear)    skew_q <= 1'b0;
        else if (skew_hit) skew_q <= 1'b1;
    end

    assign skew_err = skew_q;
`else
    // Only the last lane's valid matters here; it has a single stage.
    logic tail_vld;
    wire  unused_lane_vld = &{1'b0, in_lane_valid[LANES-2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   tail_vld <= 1'b0;
        else if (clear) tail_vld <= 1'b0;
        else            tail_vld <= in_lane_valid[LANES-1];
    end

    assign av       = tail_vld;
    assign skew_err = 1'b0;
`endif

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [LANES*DATA_W-1:0] mem [OUT_DEPTH];
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = !empty && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push  = av && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)                 wr_ptr   <= wr_ptr + PW'(1);
            if (pop)                  rd_ptr   <= rd_ptr + PW'(1);
            if (av && full && !pop)   overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else if (!clear && push) begin
            mem[wr_ptr[AW-1:0]] <= aligned_dat;
        end
    end

    assign out_valid  = !empty;
    assign out_data   = mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_systolic_deskew.sv
// Randomized and directed stimulus for systolic_deskew with a queue scoreboard and a row-level reference model.
module tb_systolic_deskew;
    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NCYC  = 1024;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic [LANES-1:0] in_lane_valid = '0;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [2:0]       fifo_level;
    logic             overflow;
    logic             skew_err;

    systolic_deskew #(.LANES(LANES), .DATA_W(DW), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_lane_valid(in_lane_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .overflow(overflow), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_xfer = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the last LANES input samples and rebuilds each row from them.
    logic [LANES-1:0] hv [LANES];
    logic [31:0]      hd [LANES];
    logic [31:0]      sb [$];
    int               m_level = 0;
    logic             m_ovf = 1'b0;
    logic             m_skew = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic [LANES-1:0] sv_slot;
        logic [31:0]      sd_slot;
        logic             av, partial, pop;
        if (!reset_n) begin
            for (int k = 0; k < LANES; k++) begin hv[k] = '0; hd[k] = '0; end
            sb.delete(); m_level = 0; m_ovf = 1'b0; m_skew = 1'b0;
        end else begin
            for (int j = 0; j < LANES; j++) begin
                sv_slot[j]          = hv[LANES-1-j][j];
                sd_slot[j*DW +: DW] = hd[LANES-1-j][j*DW +: DW];
            end
`ifdef DESKEW_ERR_CHECK_EN
            av      = &sv_slot;
            partial = (|sv_slot) && !(&sv_slot);
`else
            av      = sv_slot[LANES-1];
            partial = 1'b0;
`endif
            pop = out_ready && (m_level != 0);
            if (clear) begin
                sb.delete(); m_level = 0; m_ovf = 1'b0; m_skew = 1'b0;
                for (int k = 0; k < LANES; k++) hv[k] = '0;
            end else begin
                if (pop) m_level--;
                if (av) begin
                    if (m_level < DEPTH) begin m_level++; sb.push_back(sd_slot); end
                    else m_ovf = 1'b1;
                end
                if (partial) m_skew = 1'b1;
            end
            for (int k = LANES-1; k > 0; k--) begin hv[k] = hv[k-1]; hd[k] = hd[k-1]; end
            hv[0] = clear ? '0 : in_lane_valid;
            hd[0] = in_data;
        end
    end

    // Monitor: status checks every cycle; scoreboard pop on each real transfer.
    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_level != 0});
        chk("fifo_level", {29'd0, fifo_level}, m_level);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("skew_err", {31'd0, skew_err}, {31'd0, m_skew});
        if (out_valid && out_ready && reset_n && !clear) begin
            n_xfer++;
            if (sb.size() == 0) chk("spurious_output", 32'd1, 32'd0);
            else chk("out_data", out_data, sb.pop_front());
        end
    end

    logic [LANES-1:0] sv [NCYC];
    logic [31:0]      sd [NCYC];
    int               cur = 0;

    task automatic apply();
        in_lane_valid = sv[cur];
        in_data       = sd[cur];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur++;
        apply();
    endtask

    task automatic row(input int start, input logic [7:0] base, input int late);
        for (int j = 0; j < LANES; j++) begin
            int t;
            t = start + j + ((j == late) ? 1 : 0);
            sv[t][j] = 1'b1;
            sd[t][j*DW +: DW] = base + 8'(j);
        end
    endtask

    function automatic logic [31:0] word(input logic [7:0] base);
        logic [31:0] w;
        for (int j = 0; j < LANES; j++) w[j*DW +: DW] = base + 8'(j);
        return w;
    endfunction

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    initial begin
        int c0, x0, maxlvl;
        for (int i = 0; i < NCYC; i++) begin sv[i] = '0; sd[i] = $urandom; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_flags", {30'd0, overflow, skew_err}, 32'd0);
        reset_n = 1'b1;
        apply();

        // Single row, lanes 0x10..0x13
        row(cur, 8'h10, -1); apply();
        repeat (4) step();
        chk("single_not_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_data", out_data, 32'h13121110);
        chk("single_level", {29'd0, fifo_level}, 32'd1);
        pulse_clear();

        // Streaming 8 rows with out_ready held high
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) row(cur + r, 8'(r), -1);
        apply();
        x0 = n_xfer; maxlvl = 0;
        repeat (14) begin step(); if (int'(fifo_level) > maxlvl) maxlvl = fifo_level; end
        chk("stream_xfers", n_xfer - x0, 32'd8);
        chk("stream_level_le1", {31'd0, maxlvl <= 1}, 32'd1);
        chk("stream_ovf", {31'd0, overflow}, 32'd0);

        // Overflow: five rows, no draining
        out_ready = 1'b0; pulse_clear();
        for (int r = 0; r < 5; r++) row(cur + r, 8'h20 + 8'(r*4), -1);
        apply();
        repeat (10) step();
        chk("ovf_level", {29'd0, fifo_level}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_head", out_data, word(8'h20));
        x0 = n_xfer; out_ready = 1'b1;
        repeat (6) step();
        chk("ovf_drain_count", n_xfer - x0, 32'd4);
        chk("ovf_drained", {29'd0, fifo_level}, 32'd0);

        // Full FIFO with a pop on the edge the fifth row is pushed
        out_ready = 1'b0; pulse_clear();
        c0 = cur;
        for (int r = 0; r < 5; r++) row(cur + r, 8'h40 + 8'(r*4), -1);
        apply();
        while (cur < c0 + 8) step();
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("full_pp_level", {29'd0, fifo_level}, 32'd4);
        chk("full_pp_ovf", {31'd0, overflow}, 32'd0);
        chk("full_pp_head", out_data, word(8'h44));

        // Clear with overflow set and three entries held
        row(cur, 8'h60, -1); apply();
        repeat (6) step();
        chk("pre_clear_ovf", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("pre_clear_level", {29'd0, fifo_level}, 32'd3);
        pulse_clear();
        chk("clear_level", {29'd0, fifo_level}, 32'd0);
        chk("clear_flags", {30'd0, overflow, skew_err}, 32'd0);

        // Lane 2 one cycle late
        row(cur, 8'h70, 2); apply();
        repeat (8) step();
`ifdef DESKEW_ERR_CHECK_EN
        chk("skew_flag", {31'd0, skew_err}, 32'd1);
        chk("skew_level", {29'd0, fifo_level}, 32'd0);
`else
        chk("skew_flag", {31'd0, skew_err}, 32'd0);
        chk("skew_level", {29'd0, fifo_level}, 32'd1);
`endif
        pulse_clear();

        // Reset with 2 rows stored and 2 in flight
        row(cur, 8'h80, -1); row(cur + 1, 8'h84, -1); apply();
        repeat (7) step();
        row(cur, 8'h88, -1); row(cur + 1, 8'h8c, -1); apply();
        repeat (2) step();
        for (int i = cur; i < cur + LANES + 4; i++) sv[i] = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        apply();
        repeat (2) step();
        reset_n = 1'b1;
        x0 = n_xfer; out_ready = 1'b1;
        repeat (10) step();
        chk("post_rst_silent", n_xfer - x0, 32'd0);

        // Randomized rows, readiness, late lanes and rare clears
        repeat (600) begin
            if ($urandom_range(1, 0) == 1)
                row(cur + 1, 8'($urandom), ($urandom_range(15, 0) == 0) ? int'($urandom_range(3, 1)) : -1);
            out_ready = ($urandom_range(3, 0) != 0);
            clear     = ($urandom_range(99, 0) == 0);
            step();
        end
        clear = 1'b0; out_ready = 1'b1;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_deskew.md
# systolic_deskew

Output-side realignment buffer for the systolic array. Result columns leave the array skewed, with lane j of a row arriving j cycles after lane 0. This block delays each lane so that a row's lanes line up. It then writes each aligned row into a small circular output FIFO that a downstream consumer drains with a valid/ready handshake. The array side cannot stall, so the block never back-pressures its input; words that find the FIFO full are dropped and flagged.

## Interface
- LANES, 16, number of result lanes (columns); ≥2
- DATA_W, 8, bits per lane element
- OUT_DEPTH, 4, output FIFO entries; power of 2, ≥2

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear: empties FIFO, zeroes delay-line valid bits, clears sticky flags
- in_lane_valid  in  LANES  per-lane valid, skewed (lane j of a row is asserted j cycles after lane 0)
- in_data  in  LANES*DATA_W  per-lane data, skewed; lane j occupies bits [j*DATA_W +: DATA_W]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data on an edge where out_valid=1
- out_data  out  LANES*DATA_W  aligned row at the FIFO head; same lane packing as in_data
- fifo_level  out  $clog2(OUT_DEPTH)+1  entries currently held
- overflow  out  1  sticky: an aligned word was dropped because the FIFO was full
- skew_err  out  1  sticky: an aligned slot had a partial set of lane valids

## Operation
- Delay lines:
  - Lane j has a free-running delay line of LANES-j stages for both data and valid; lane 0 has LANES stages, lane LANES-1 has 1 stage.
  - The lines always shift, with no enable.
  - All stages reset to 0.
- Aligned slot: the last stage of every lane. A row whose lane 0 is sampled at edge E0 occupies the aligned slot in full after edge E0+LANES-1.
- Aligned valid (av), with DESKEW_ERR_CHECK_EN defined: av = AND of all last-stage valid bits.
- Skew error:
  - If the last-stage valid bits are a mix of 1s and 0s: skew_err is set, no word is written, and the partial data is discarded.
- Push: av=1 → write the aligned data into mem[wr_ptr] on the next edge.
- Pop: out_valid && out_ready → advance rd_ptr.
- Pointers:
  - wr_ptr and rd_ptr are each $clog2(OUT_DEPTH)+1 bits; the MSB is the wrap bit.
  - full when the low bits are equal and the MSBs differ.
  - empty when the pointers are equal.
- out_data = mem[rd_ptr], read combinationally. out_data is don't-care when out_valid=0 but equals 0 after reset.
- Full FIFO, no pop, av=1: the word is dropped and overflow is set; pointers and level are unchanged.
- Full FIFO, pop and av=1 on the same edge: both happen; fifo_level stays at OUT_DEPTH; no overflow.
- Empty FIFO, av=1: the word is written; out_valid rises after that edge. There is no combinational bypass.
- clear: takes priority over push and pop on the same edge.
  - Pointers → 0, all delay-line valid bits → 0, overflow and skew_err → 0.
  - Data contents are kept.
- Reset values: out_valid 0, out_data 0 (mem and delay data reset to 0), fifo_level 0, overflow 0, skew_err 0.
- Reset mid-operation: immediately returns every register to its reset value; in-flight rows are lost.

## Timing
- Latency: lane-0 sample edge E0 → word in FIFO and out_valid=1 after edge E0+LANES.
- Throughput: one aligned row per cycle in and one pop per cycle out.
- fifo_level updates on the same edge as the push or pop that changes it.
- Sticky flags assert on the edge following the offending aligned slot.
- Sticky flags deassert only on clear or reset.

## Configuration
- DESKEW_ERR_CHECK_EN defined: aligned-valid and skew-error behaviour exactly as in Operation.
- DESKEW_ERR_CHECK_EN undefined:
  - av = last-stage valid of lane LANES-1 only.
  - Other lanes' valid bits are not stored.
  - The word is written using whatever data sits in the aligned slot.
  - skew_err is tied to 0.

## Test plan
Configuration for all scenarios: LANES=4, DATA_W=8, OUT_DEPTH=4, DESKEW_ERR_CHECK_EN defined unless stated.
- Single row:
  - Stimulus: lane j valid with data 0x10+j at edge j only, out_ready=0.
  - Required response: out_valid=1 after edge 4; out_data=0x13121110; fifo_level=1.
- Streaming:
  - Stimulus: 8 back-to-back rows with lane-0 values 0x00..0x07, out_ready=1.
  - Required response: 8 consecutive outputs in order with no gaps; fifo_level ≤1; overflow=0.
- Overflow:
  - Stimulus: out_ready=0, 5 rows.
  - Required response: fifo_level=4; overflow=1 after the 5th aligned slot; draining then yields rows 1–4 in order, and row 5 is absent.
- Full with simultaneous push/pop:
  - Stimulus: FIFO holding 4 entries; out_ready=1 on the same edge a 5th aligned word arrives.
  - Required response: level stays 4; overflow=0; head advances by one.
- Skew error:
  - Stimulus: lane 2 asserted one cycle late.
  - Required response: skew_err=1; no word written; fifo_level unchanged.
  - Same stimulus with the macro undefined: word written; skew_err=0.
- Reset and clear:
  - Stimulus: reset_n pulsed low with 2 rows in flight and 2 entries stored.
  - Required response: all outputs 0 immediately, and nothing emerges afterwards.
  - clear with overflow=1 and 3 entries stored: level 0, flags 0 on the next edge.
